// File: rtl/sreg_pkg.sv
// Shared types for the scalar register-file request sequencer.
// Pure declarations; no logic and no latency of its own.
// No flow control; used by sreg_req_fifo and sreg_seq.
package sreg_pkg;

  // Default widths of the request payload carried through the FIFO
  localparam int SREG_ADDR_W = 3;
  localparam int SREG_DATA_W = 16;

  // Request opcodes as they appear on ReqOp
  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_WRL = 2'b10,
    OP_WRH = 2'b11
  } op_t;

  // Register-file access phases
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } state_t;

  // One queued request
  typedef struct packed {
    op_t                    op;
    logic [SREG_ADDR_W-1:0] addr;
    logic [SREG_DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/sreg_if.sv
// Bundle of request/response handshakes and register-file pins around sreg_seq.
// Wires only; no latency.
// ReqValid/ReqReady and RspValid/RspReady carry the backpressure.
interface sreg_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);
  logic              ReqValid;
  logic              ReqReady;
  logic [1:0]        ReqOp;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqData;
  logic              RspValid;
  logic              RspReady;
  logic [DATA_W-1:0] RspData;
  logic              Busy;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] DataIn;
  logic              RD;
  logic              WR;
  logic              WR_l;
  logic              WR_h;
  logic [DATA_W-1:0] DataOut;

  // Sequencer side
  modport slave (
    input  ReqValid, ReqOp, ReqAddr, ReqData, RspReady, DataOut,
    output ReqReady, RspValid, RspData, Busy, Addr, DataIn, RD, WR, WR_l, WR_h
  );

  // Execute stage plus register file side
  modport master (
    output ReqValid, ReqOp, ReqAddr, ReqData, RspReady, DataOut,
    input  ReqReady, RspValid, RspData, Busy, Addr, DataIn, RD, WR, WR_l, WR_h
  );
endinterface

// File: rtl/sreg_req_fifo.sv
// Small circular request FIFO with head peek (and head+1 peek / dual pop when SREG_HALF_MERGE_EN).
// Zero-latency head view; an entry pushed at an edge is visible at head after that edge.
// Caller must not push when full or pop past count; simultaneous push and pop keeps count.
module sreg_req_fifo
  import sreg_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  req_t                   push_dat,
  input  logic                   pop,
`ifdef SREG_HALF_MERGE_EN
  input  logic                   pop2,
  output req_t                   nxt,
`endif
  output logic [$clog2(DEPTH):0] count,
  output req_t                   head
);
  localparam int PW = $clog2(DEPTH);

  req_t          mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   pop_n;

  assign head = mem[rd_ptr];

  // Number of entries leaving this cycle
`ifdef SREG_HALF_MERGE_EN
  assign nxt   = mem[rd_ptr + PW'(1)];
  assign pop_n = pop2 ? (PW+1)'(2) : (pop ? (PW+1)'(1) : '0);
`else
  assign pop_n = pop ? (PW+1)'(1) : '0;
`endif

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + {{PW{1'b0}}, push} - pop_n;
    end
  end
endmodule

// File: rtl/sreg_seq.sv
// Sequencer feeding the scalar register file: queues requests and drives Addr/DataIn/strobes; SREG_HALF_MERGE_EN fuses write-low+write-high.
// Accept to strobe 3 cycles, read response 5 cycles after accept; back-to-back writes strobe every 3 cycles.
// ReqReady drops when the FIFO is full; RESP holds until RspReady, stalling the queue behind it.
module sreg_seq
  import sreg_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = SREG_ADDR_W,
  parameter int DATA_W = SREG_DATA_W
) (
  input logic  Clk,
  input logic  Rst,
  sreg_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     count;
  logic              fifo_ne;
  logic              push;
  logic              pop;
  logic              merge_ok;
  req_t              push_req;
  req_t              head;
  state_t            state_q;
  state_t            state_d;
  op_t               op_q;
  op_t               load_op;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_vld_q;
  logic              rd_q;
  logic              wr_q;
  logic              wrl_q;
  logic              wrh_q;

  assign fifo_ne  = (count != '0);
  assign bus.ReqReady = !Rst && (count < CW'(DEPTH));
  assign push     = bus.ReqValid && bus.ReqReady;
  assign push_req = '{op: op_t'(bus.ReqOp), addr: bus.ReqAddr, data: bus.ReqData};

`ifdef SREG_HALF_MERGE_EN
  req_t nxt;

  // Low half followed by high half of the same register can go out as one full write
  assign merge_ok = (count >= CW'(2)) && (head.op == OP_WRL) &&
                    (nxt.op == OP_WRH) && (nxt.addr == head.addr);

  sreg_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(Clk), .rst(Rst), .push(push), .push_dat(push_req), .pop(pop),
    .pop2(pop && merge_ok), .nxt(nxt), .count(count), .head(head)
  );

  // Opcode/data latched at pop, fused when merging
  always_comb begin
    load_op   = head.op;
    load_data = head.data;
    if (merge_ok) begin
      load_op   = OP_WR;
      load_data = {nxt.data[DATA_W-1:DATA_W/2], head.data[DATA_W/2-1:0]};
    end
  end
`else
  assign merge_ok = 1'b0;

  sreg_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(Clk), .rst(Rst), .push(push), .push_dat(push_req), .pop(pop),
    .count(count), .head(head)
  );

  // Opcode/data latched at pop
  always_comb begin
    load_op   = head.op;
    load_data = head.data;
  end
`endif

  // Next-state and pop decision; every pop point enters SETUP
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_ne) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = HOLD;
      HOLD: begin
        if (op_q == OP_RD) begin
          state_d = RESP;
        end else if (fifo_ne) begin
          pop     = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (bus.RspReady) begin
          if (fifo_ne) begin
            pop     = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand registers and registered strobes so the register file sees glitch-free levels
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      op_q       <= OP_RD;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_vld_q  <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wrl_q      <= 1'b0;
      wrh_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        op_q   <= load_op;
        addr_q <= head.addr;
        data_q <= load_data;
      end
      if (state_q == HOLD && op_q == OP_RD) rsp_data_q <= bus.DataOut;
      rsp_vld_q <= (state_d == RESP);
      rd_q      <= (state_d == STROBE) && (op_q == OP_RD);
      wr_q      <= (state_d == STROBE) && (op_q == OP_WR);
      wrl_q     <= (state_d == STROBE) && (op_q == OP_WRL);
      wrh_q     <= (state_d == STROBE) && (op_q == OP_WRH);
    end
  end

  assign bus.Addr     = addr_q;
  assign bus.DataIn   = data_q;
  assign bus.RD       = rd_q;
  assign bus.WR       = wr_q;
  assign bus.WR_l     = wrl_q;
  assign bus.WR_h     = wrh_q;
  assign bus.RspValid = rsp_vld_q;
  assign bus.RspData  = rsp_data_q;
  assign bus.Busy     = !Rst && (push || fifo_ne || (state_q != IDLE));
endmodule

// File: doc/sreg_seq.md
Name: sreg_seq

Overview:
- Request sequencer directly upstream of the eight-entry 16-bit scalar register file.
- Accepts scalar read, write, write-low and write-high requests from the execute stage over a valid/ready handshake, buffers them in a small FIFO, and drives the register file's Addr/DataIn/RD/WR/WR_l/WR_h pins.
- Holds Addr stable one cycle before and one cycle after every strobe, because the register file decodes address and strobes level-sensitively. Returns read data over a response handshake.

Parameters:
- DEPTH, 2, request FIFO entries (power of two, >=2)
- ADDR_W, 3, scalar register address width
- DATA_W, 16, scalar data width (must be even)

Ports:
- Clk  input  1  single clock, all state on rising edge
- Rst  input  1  synchronous active-high reset
- ReqValid  input  1  request present
- ReqReady  output  1  FIFO can accept this cycle
- ReqOp  input  2  00 read, 01 write, 10 write-low, 11 write-high
- ReqAddr  input  ADDR_W  target scalar register
- ReqData  input  DATA_W  write data (ignored for read)
- RspValid  output  1  read data available
- RspReady  input  1  consumer takes response
- RspData  output  DATA_W  read result
- Busy  output  1  FIFO non-empty or FSM not IDLE
- Addr  output  ADDR_W  to register file
- DataIn  output  DATA_W  to register file
- RD, WR, WR_l, WR_h  output  1 each  register file strobes, at most one high
- DataOut  input  DATA_W  from register file

Behaviour:
- Clock/reset: one clock (Clk); reset synchronous, active-high (Rst). While Rst is high: FIFO flushed; state IDLE; Addr=0, DataIn=0, all strobes 0, RspValid=0, RspData=0, ReqReady=0, Busy=0. ReqReady=1 from the first cycle after Rst falls.
- Reset mid-operation: strobes drop at the reset edge; any pending response is discarded; register file contents are untouched.
- Push: ReqValid&&ReqReady. ReqReady = (count<DEPTH), registered-free (combinational from count). Simultaneous push and pop in one cycle leaves count unchanged; a push into a full FIFO cannot occur.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into op/addr/data registers and go to SETUP.
  - SETUP (1 cycle): Addr/DataIn driven from op registers, strobes 0.
  - STROBE (1 cycle): exactly one strobe high per op (read->RD, write->WR, write-low->WR_l, write-high->WR_h); Addr/DataIn held.
  - HOLD (1 cycle): strobes 0, Addr/DataIn held.
    - Read: RspData<=DataOut at the end of HOLD, then go to RESP.
    - Write with FIFO non-empty: pop and go to SETUP.
    - Otherwise: go to IDLE.
  - RESP: RspValid=1, RspData stable until RspReady. On handshake, pop and go to SETUP if the FIFO is non-empty, else go to IDLE.
- Addr/DataIn keep their last values in IDLE/RESP; never change while any strobe is high.
- Latency:
  - Request accepted at cycle T from an empty, IDLE block: IDLE pop at T+1, SETUP T+2, strobe at T+3, HOLD T+4.
  - Read: RspValid first at T+5.
  - Back-to-back writes: one strobe every 3 cycles.
- Ordering: strict FIFO order; a read after a write to the same address returns the new value.
- Busy high from the push cycle through the cycle before return to IDLE.

Optional Feature:
- Macro: SREG_HALF_MERGE_EN.
- Defined: at pop time, if the head is write-low and the next entry is write-high to the same address, both entries are popped in the same cycle and one WR strobe is issued with DataIn = {next.data[DATA_W-1:DATA_W/2], head.data[DATA_W/2-1:0]}. The merge saves 3 cycles. Reverse order or different addresses are not merged.
- Undefined: every entry is issued individually; no dual-pop logic is present.

Decomposition:
- Package sreg_pkg:
  - op encoding constants OP_RD, OP_WR, OP_WRL, OP_WRH
  - FSM state typedef (IDLE, SETUP, STROBE, HOLD, RESP)
  - request struct {op, addr, data}
- Sub-module sreg_req_fifo:
  - parameterised DEPTH
  - push/pop, count, head and head+1 peek (peek used by the merge feature)

Test Plan:
- Reset then write r3=0xBEEF, read r3 -> one WR pulse with Addr=3 and DataIn=0xBEEF; Addr is stable in the cycle before and after the pulse; RspValid at T+5 with RspData=0xBEEF.
- Write-low r1=0x00AA, then write-high r1=0x5500 after r1=0x1234 -> read returns 0x55AA. With SREG_HALF_MERGE_EN: a single WR pulse with DataIn=0x55AA.
- Three writes pushed back-to-back with DEPTH=2 -> ReqReady falls when the FIFO is full; all three strobes arrive in order, 3 cycles apart.
- Read r7 with RspReady held low 5 cycles -> RspValid and RspData stay constant; the next queued write does not strobe until the handshake completes.
- Rst asserted during STROBE of a queued write -> strobes are 0 on the next cycle; FIFO is empty; Busy=0; RspValid=0.
- Random op mix with a reference model -> at most one strobe is ever high; read data matches the model.
